// File: rtl/span_cme_host_loader.sv
// span_cme_host_loader: bus master for the SPAN CME margin register slave.
// Each run clears the slave's compute-start strobes, streams the parameter map
// from a synchronous-read parameter RAM into the slave, waits a settle interval,
// then reads back the initial margin and reports it with a one-cycle done pulse.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   start               : run request, honoured only while idle
//   src_addr/src_rd     : parameter RAM read port (address, read enable)
//   src_data            : parameter RAM data, valid the cycle after src_rd
//   chipselect/write/read/offset/writeData : slave bus (registered strobes)
//   readData            : slave read data, valid the cycle after read
//   busy                : run in progress (CLEAR through CAPTURE)
//   done                : one-cycle pulse, margin has just been updated
//   margin              : last captured initial margin
`timescale 1ns/1ps
module span_cme_host_loader #(
   parameter int unsigned NUM_REGS      = 34,
   parameter int unsigned CLEAR_OFFSET  = 63,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [5:0]  src_addr,
   output logic        src_rd,
   input  logic [15:0] src_data,
   output logic        chipselect,
   output logic        write,
   output logic        read,
   output logic [5:0]  offset,
   output logic [15:0] writeData,
   input  logic [15:0] readData,
   output logic        busy,
   output logic        done,
   output logic [15:0] margin
);

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_WRITE   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_READ    = 3'd4,
      ST_CAPTURE = 3'd5
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   k_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                cs_q;
   logic                wr_q;
   logic                rd_q;
   logic [ADDR_W-1:0]   off_q;
   logic                src_rd_q;
   logic [ADDR_W-1:0]   src_addr_q;
   logic                wdata_sel_q;
   logic                busy_q;
   logic                done_q;
   logic [DATA_W-1:0]   margin_q;

   // Sequencer: every register below holds the value for the *next* cycle, so
   // each branch sets up the bus for the state it is entering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         cnt_q       <= '0;
         cs_q        <= 1'b0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         off_q       <= '0;
         src_rd_q    <= 1'b0;
         src_addr_q  <= '0;
         wdata_sel_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         margin_q    <= '0;
      end else begin
         cs_q        <= 1'b0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         off_q       <= '0;
         src_rd_q    <= 1'b0;
         src_addr_q  <= '0;
         wdata_sel_q <= 1'b0;
         done_q      <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  // Enter CLEAR: write 0 to the unmapped offset and fetch word 0.
                  state_q    <= ST_CLEAR;
                  busy_q     <= 1'b1;
                  cs_q       <= 1'b1;
                  wr_q       <= 1'b1;
                  off_q      <= ADDR_W'(CLEAR_OFFSET);
                  src_rd_q   <= 1'b1;
                  src_addr_q <= '0;
               end
            end

            ST_CLEAR: begin
               // Enter WRITE k=0; word 0 arrives from the RAM this coming cycle.
               state_q     <= ST_WRITE;
               k_q         <= '0;
               cs_q        <= 1'b1;
               wr_q        <= 1'b1;
               off_q       <= '0;
               wdata_sel_q <= 1'b1;
               src_rd_q    <= (NUM_REGS > 1);
               src_addr_q  <= ADDR_W'(1);
            end

            ST_WRITE: begin
               if (k_q == LAST_K) begin
                  if (SETTLE_CYCLES == 0) begin
                     state_q <= ST_READ;
                     cs_q    <= 1'b1;
                     rd_q    <= 1'b1;
                     off_q   <= '0;
                  end else begin
                     state_q <= ST_SETTLE;
                     cnt_q   <= CNT_W'(SETTLE_CYCLES);
                  end
               end else begin
                  // Next write k+1; prefetch k+2 only while it is still mapped.
                  k_q         <= k_q + ADDR_W'(1);
                  cs_q        <= 1'b1;
                  wr_q        <= 1'b1;
                  off_q       <= k_q + ADDR_W'(1);
                  wdata_sel_q <= 1'b1;
                  src_rd_q    <= ((32'(k_q) + 32'd2) < NUM_REGS);
                  src_addr_q  <= k_q + ADDR_W'(2);
               end
            end

            ST_SETTLE: begin
               // Counter starts at SETTLE_CYCLES, so leaving at 1 gives exactly that many idle cycles.
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_READ;
                  cs_q    <= 1'b1;
                  rd_q    <= 1'b1;
                  off_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            ST_READ: begin
               // Slave registers readData; it is valid during CAPTURE.
               state_q <= ST_CAPTURE;
            end

            ST_CAPTURE: begin
               state_q  <= ST_IDLE;
               margin_q <= readData;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign src_addr   = src_addr_q;
   assign src_rd     = src_rd_q;
   assign chipselect = cs_q;
   assign write      = wr_q;
   assign read       = rd_q;
   assign offset     = off_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign margin     = margin_q;

   // The RAM delivers the word one cycle after its read, exactly when the
   // matching write is on the bus, so the data path is steered by a registered
   // select instead of being re-registered (which would add a cycle).
   assign writeData  = wdata_sel_q ? src_data : '0;

endmodule

// File: tb/tb_span_cme_host_loader.sv
`timescale 1ns/1ps
module tb_span_cme_host_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, start0;
   logic [15:0] slave_val;
   logic [15:0] ram [64];

   // Default-parameter instance
   logic [5:0]  src_addr, offset;
   logic        src_rd, chipselect, write, read, busy, done;
   logic [15:0] src_data, writeData, readData, margin;

   // SETTLE_CYCLES = 0 instance
   logic [5:0]  src_addr0, offset0;
   logic        src_rd0, chipselect0, write0, read0, busy0, done0;
   logic [15:0] src_data0, writeData0, readData0, margin0;

   span_cme_host_loader dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
      .chipselect(chipselect), .write(write), .read(read), .offset(offset),
      .writeData(writeData), .readData(readData),
      .busy(busy), .done(done), .margin(margin)
   );

   span_cme_host_loader #(.NUM_REGS(34), .CLEAR_OFFSET(63), .SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0),
      .src_addr(src_addr0), .src_rd(src_rd0), .src_data(src_data0),
      .chipselect(chipselect0), .write(write0), .read(read0), .offset(offset0),
      .writeData(writeData0), .readData(readData0),
      .busy(busy0), .done(done0), .margin(margin0)
   );

   // Synchronous-read parameter RAM and registered-read slave models
   always_ff @(posedge clk) begin
      if (src_rd)  src_data  <= ram[src_addr];
      if (src_rd0) src_data0 <= ram[src_addr0];
      if (chipselect && read)   readData  <= slave_val;
      if (chipselect0 && read0) readData0 <= slave_val;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard for the default instance
   typedef struct packed { logic [5:0] off; logic [15:0] data; } wr_t;
   wr_t         wq[$];
   logic [15:0] mq[$];
   int          done_cnt = 0;

   task automatic push_run(input logic [15:0] m);
      wq.push_back('{off: 6'd63, data: 16'h0000});
      for (int k = 0; k < 34; k++) wq.push_back('{off: 6'(k), data: ram[k]});
      mq.push_back(m);
   endtask

   always @(posedge clk) begin
      wr_t e;
      #1;
      if (write || read) begin
         chk("strobe_needs_cs", {31'b0, chipselect}, 32'd1);
         chk("rd_wr_exclusive", {31'b0, write && read}, 32'd0);
      end
      if (chipselect && write) begin
         n_tests++;
         if (wq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: offset=%0d data=0x%h with nothing expected", offset, writeData);
         end else begin
            e = wq.pop_front();
            chk("wr_offset", {26'b0, offset}, {26'b0, e.off});
            chk("wr_data", {16'b0, writeData}, {16'b0, e.data});
         end
      end
      if (done) begin
         done_cnt++;
         n_tests++;
         if (mq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: margin=0x%h with no run pending", margin);
         end else begin
            chk("margin_on_done", {16'b0, margin}, {16'b0, mq.pop_front()});
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle checkpoints of a default run
   typedef struct {
      int         cyc;
      logic       cs, wr, rd, srd;
      logic [5:0] off, saddr;
      logic       bsy, dn;
   } vec_t;
   vec_t tbl [11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int done_at;

      tbl[0]  = '{1,  1'b1, 1'b1, 1'b0, 1'b1, 6'd63, 6'd0,  1'b1, 1'b0};
      tbl[1]  = '{2,  1'b1, 1'b1, 1'b0, 1'b1, 6'd0,  6'd1,  1'b1, 1'b0};
      tbl[2]  = '{5,  1'b1, 1'b1, 1'b0, 1'b1, 6'd3,  6'd4,  1'b1, 1'b0};
      tbl[3]  = '{34, 1'b1, 1'b1, 1'b0, 1'b1, 6'd32, 6'd33, 1'b1, 1'b0};
      tbl[4]  = '{35, 1'b1, 1'b1, 1'b0, 1'b0, 6'd33, 6'd0,  1'b1, 1'b0};
      tbl[5]  = '{36, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0};
      tbl[6]  = '{51, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0};
      tbl[7]  = '{52, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0};
      tbl[8]  = '{53, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0};
      tbl[9]  = '{54, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 1'b1};
      tbl[10] = '{55, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0};

      for (int k = 0; k < 64; k++) ram[k] = 16'h0100 + 16'(k);
      slave_val = 16'h1234;
      reset  = 1'b1;
      start  = 1'b0;
      start0 = 1'b0;
      repeat (3) next_cycle();

      // Reset state
      chk("rst_cs",     {31'b0, chipselect}, 0);
      chk("rst_write",  {31'b0, write}, 0);
      chk("rst_read",   {31'b0, read}, 0);
      chk("rst_src_rd", {31'b0, src_rd}, 0);
      chk("rst_busy",   {31'b0, busy}, 0);
      chk("rst_done",   {31'b0, done}, 0);
      chk("rst_margin", {16'b0, margin}, 0);
      chk("rst_offset", {26'b0, offset}, 0);
      chk("rst_wdata",  {16'b0, writeData}, 0);
      chk("rst0_busy",  {31'b0, busy0}, 0);
      chk("rst0_cs",    {31'b0, chipselect0}, 0);
      reset = 1'b0;
      next_cycle();

      // Run 1: defaults, with ignored start pulses at cycles 5 and 30
      start = 1'b1;
      push_run(16'h1234);
      base = done_cnt;
      for (int c = 1; c <= 55; c++) begin
         next_cycle();
         for (int i = 0; i < 11; i++) begin
            if (tbl[i].cyc == c) begin
               chk($sformatf("c%0d_cs", c),     {31'b0, chipselect}, {31'b0, tbl[i].cs});
               chk($sformatf("c%0d_write", c),  {31'b0, write},      {31'b0, tbl[i].wr});
               chk($sformatf("c%0d_read", c),   {31'b0, read},       {31'b0, tbl[i].rd});
               chk($sformatf("c%0d_src_rd", c), {31'b0, src_rd},     {31'b0, tbl[i].srd});
               chk($sformatf("c%0d_busy", c),   {31'b0, busy},       {31'b0, tbl[i].bsy});
               chk($sformatf("c%0d_done", c),   {31'b0, done},       {31'b0, tbl[i].dn});
               if (tbl[i].cs)  chk($sformatf("c%0d_offset", c),   {26'b0, offset},   {26'b0, tbl[i].off});
               if (tbl[i].srd) chk($sformatf("c%0d_src_addr", c), {26'b0, src_addr}, {26'b0, tbl[i].saddr});
            end
         end
         start = (c == 5 || c == 30);
      end
      chk("run1_writes_left", wq.size(), 0);
      chk("run1_done_count", done_cnt - base, 1);
      chk("run1_margin_hold", {16'b0, margin}, 32'h1234);

      // Reset during WRITE k=10 (cycle 12)
      slave_val = 16'h5A5A;
      start = 1'b1;
      push_run(16'h5A5A);
      for (int c = 1; c <= 12; c++) begin
         next_cycle();
         if (c == 1) start = 1'b0;
      end
      chk("k10_write",  {31'b0, write}, 1);
      chk("k10_offset", {26'b0, offset}, 10);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      wq.delete();
      mq.delete();
      chk("mrst_cs",     {31'b0, chipselect}, 0);
      chk("mrst_write",  {31'b0, write}, 0);
      chk("mrst_read",   {31'b0, read}, 0);
      chk("mrst_busy",   {31'b0, busy}, 0);
      chk("mrst_margin", {16'b0, margin}, 0);
      repeat (5) next_cycle();
      chk("mrst_still_idle", {31'b0, busy}, 0);

      // Complete run after the mid-run reset
      start = 1'b1;
      push_run(16'h5A5A);
      done_at = -1;
      for (int c = 1; c <= 80; c++) begin
         next_cycle();
         if (c == 1) start = 1'b0;
         if (done) begin
            done_at = c;
            break;
         end
      end
      chk("rerun_done_cycle", done_at, 54);
      chk("rerun_writes_left", wq.size(), 0);

      // start held high: back-to-back runs
      next_cycle();
      slave_val = 16'h1111;
      start = 1'b1;
      push_run(16'h1111);
      push_run(16'hBEEF);
      base = done_cnt;
      for (int c = 1; c <= 110; c++) begin
         next_cycle();
         if (c == 54) begin
            chk("b2b_done1", {31'b0, done}, 1);
            chk("b2b_margin1", {16'b0, margin}, 32'h1111);
            slave_val = 16'hBEEF;
         end
         if (c == 55) begin
            chk("b2b_clear_cs",    {31'b0, chipselect}, 1);
            chk("b2b_clear_write", {31'b0, write}, 1);
            chk("b2b_clear_off",   {26'b0, offset}, 63);
            start = 1'b0;
         end
         if (c == 108) chk("b2b_done2", {31'b0, done}, 1);
      end
      chk("b2b_done_count", done_cnt - base, 2);
      chk("b2b_margin2", {16'b0, margin}, 32'hBEEF);
      chk("b2b_writes_left", wq.size(), 0);

      // SETTLE_CYCLES = 0 instance: read right after the last write
      slave_val = 16'h0C0D;
      start0 = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         next_cycle();
         if (c == 1) start0 = 1'b0;
         chk($sformatf("s0_c%0d_write", c), {31'b0, write0}, {31'b0, (c <= 35)});
         chk($sformatf("s0_c%0d_read", c),  {31'b0, read0},  {31'b0, (c == 36)});
         chk($sformatf("s0_c%0d_done", c),  {31'b0, done0},  {31'b0, (c == 38)});
         if (c == 35) begin
            chk("s0_last_off",  {26'b0, offset0}, 33);
            chk("s0_last_data", {16'b0, writeData0}, {16'b0, ram[33]});
         end
         if (c == 36) chk("s0_read_off", {26'b0, offset0}, 0);
         if (c == 38) chk("s0_margin", {16'b0, margin0}, 32'h0C0D);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
